// File: rtl/wb_stage_buf_pkg.sv
// Shared definitions for the MEM/WB writeback stage.
// Holds the default lane geometry, the writeback entry record and a helper
// that gives the packed width of an entry for any lane geometry.
package wb_pkg;

  localparam int XLEN_DEF      = 64;
  localparam int NLANES_DEF    = 1;
  localparam int REGADDR_W_DEF = 5;
  localparam int CNT_W_DEF     = 32;

  // One buffered writeback entry at the default geometry.
  typedef struct packed {
    logic                               regwrite;
    logic [REGADDR_W_DEF-1:0]           dst;
    logic [NLANES_DEF-1:0]              lane_en;
    logic [NLANES_DEF*XLEN_DEF-1:0]     wdata;
  } wb_entry_t;

  localparam int WB_ENTRY_W = $bits(wb_entry_t);

  // Packed entry width for an arbitrary lane geometry; field order matches wb_entry_t.
  function automatic int entryWidth(input int xlen, input int nlanes, input int regaddrW);
    return 1 + regaddrW + nlanes + nlanes * xlen;
  endfunction

endpackage

// File: rtl/wb_stage_buf_rv_fifo2.sv
// rv_fifo2: generic 2-entry valid/ready FIFO (head + skid register).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flush_i                   drop all stored entries and any same-cycle push
//   in_valid_i / in_ready_o   upstream handshake; ready depends only on state and rst
//   in_data_i                 payload to enqueue
//   out_valid_o / out_ready_i downstream handshake
//   out_data_o                head payload (zero when empty)
module rv_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic [1:0]   count_q, count_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] skid_q, skid_d;
  logic         push;
  logic         pop;

  // Ready is derived from occupancy only, so out_ready never reaches in_ready.
  assign in_ready_o  = (count_q < 2'd2) && !rst;
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = head_q;

  assign push = in_valid_i && in_ready_o && !flush_i;
  assign pop  = out_valid_o && out_ready_i;

  // Next-state for occupancy and storage. Vacated slots are cleared so an
  // empty FIFO always presents zero on out_data_o.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush_i) begin
      count_d = 2'd0;
      head_d  = '0;
      skid_d  = '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_d = in_data_i;
          end else begin
            skid_d = in_data_i;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          // With one entry the skid is already zero, so head clears too.
          head_d  = skid_q;
          skid_d  = '0;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Only reachable with one entry: the new entry replaces the head.
          head_d = in_data_i;
        end
        default: begin
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/wb_stage_buf.sv
// wb_stage_buf: MEM/WB stage register with a 2-entry skid buffer.
// Selects load data or ALU result at enqueue, suppresses writes to x0,
// exposes the head entry for forwarding and counts retired register writes.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           MEM-stage handshake
//   in_memtoreg, in_regwrite      writeback source select, register write enable
//   in_dst, in_lane_en            destination register, per-lane enables
//   in_dmemrd, in_aluresult       lane-packed load data / ALU result
//   flush                         discard buffered and incoming entries
//   out_valid / out_ready         register-file handshake
//   out_regwrite, out_dst,
//   out_lane_en, out_wdata        head entry (zero when empty)
//   retire_cnt                    popped entries that wrote a register
module wb_stage_buf
  import wb_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int NLANES    = NLANES_DEF,
  parameter int REGADDR_W = REGADDR_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_memtoreg,
  input  logic                   in_regwrite,
  input  logic [REGADDR_W-1:0]   in_dst,
  input  logic [NLANES-1:0]      in_lane_en,
  input  logic [NLANES*XLEN-1:0] in_dmemrd,
  input  logic [NLANES*XLEN-1:0] in_aluresult,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_regwrite,
  output logic [REGADDR_W-1:0]   out_dst,
  output logic [NLANES-1:0]      out_lane_en,
  output logic [NLANES*XLEN-1:0] out_wdata,
  output logic [CNT_W-1:0]       retire_cnt
);

  typedef struct packed {
    logic                   regwrite;
    logic [REGADDR_W-1:0]   dst;
    logic [NLANES-1:0]      lane_en;
    logic [NLANES*XLEN-1:0] wdata;
  } entry_t;

  localparam int ENTRY_W = entryWidth(XLEN, NLANES, REGADDR_W);

  entry_t             enqEntry;
  entry_t             headEntry;
  logic [ENTRY_W-1:0] fifoHead;
  logic               pop;
  logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;

  // Build the stored entry: the data mux is resolved here so memtoreg never
  // needs to be buffered, and x0 writes are turned into no-ops.
  always_comb begin
    enqEntry          = '0;
    enqEntry.regwrite = in_regwrite && (in_dst != '0);
    enqEntry.dst      = in_dst;
    enqEntry.lane_en  = in_lane_en;
    enqEntry.wdata    = in_memtoreg ? in_dmemrd : in_aluresult;
  end

  rv_fifo2 #(
    .W(ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (enqEntry),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (fifoHead)
  );

  assign headEntry = fifoHead;

  // Explicit zeroing keeps the forwarding outputs clean while empty.
  assign out_regwrite = out_valid ? headEntry.regwrite : 1'b0;
  assign out_dst      = out_valid ? headEntry.dst      : '0;
  assign out_lane_en  = out_valid ? headEntry.lane_en  : '0;
  assign out_wdata    = out_valid ? headEntry.wdata    : '0;

  assign pop = out_valid && out_ready;

  // A pop still retires even when flush hits in the same cycle.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (pop && out_regwrite) begin
      retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_stage_buf.sv
// Testbench for wb_stage_buf with a 4-lane, 16-bit-lane, 4-bit-counter instance.
// A queue-based model is checked against the DUT every cycle, and directed
// scenarios add hand-computed expectations.
module tb_wb_stage_buf;

  localparam int XLEN   = 16;
  localparam int NLANES = 4;
  localparam int RAW    = 5;
  localparam int CW     = 4;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic        inMemtoreg;
  logic        inRegwrite;
  logic [4:0]  inDst;
  logic [3:0]  inLaneEn;
  logic [63:0] inDmemrd;
  logic [63:0] inAlu;
  logic        flush;
  logic        outValid;
  logic        outReady;
  logic        outRegwrite;
  logic [4:0]  outDst;
  logic [3:0]  outLaneEn;
  logic [63:0] outWdata;
  logic [3:0]  retireCnt;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  wb_stage_buf #(
    .XLEN(XLEN), .NLANES(NLANES), .REGADDR_W(RAW), .CNT_W(CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (inValid),
    .in_ready     (inReady),
    .in_memtoreg  (inMemtoreg),
    .in_regwrite  (inRegwrite),
    .in_dst       (inDst),
    .in_lane_en   (inLaneEn),
    .in_dmemrd    (inDmemrd),
    .in_aluresult (inAlu),
    .flush        (flush),
    .out_valid    (outValid),
    .out_ready    (outReady),
    .out_regwrite (outRegwrite),
    .out_dst      (outDst),
    .out_lane_en  (outLaneEn),
    .out_wdata    (outWdata),
    .retire_cnt   (retireCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      passCount++;
    end
  endtask

  // Model: an ordered queue of entries plus a retire counter.
  typedef struct {
    logic        rw;
    logic [4:0]  dst;
    logic [3:0]  le;
    logic [63:0] wd;
  } ent_t;

  ent_t       mq[$];
  logic [3:0] mRetire = 4'd0;
  bit         mLive   = 1'b0;

  // Compare the DUT against the model on each falling edge, then advance the
  // model by the inputs that the next rising edge will see.
  always @(negedge clk) begin
    ent_t head;
    ent_t e;
    bit   expValid;
    bit   mPop;
    bit   mPush;
    bit   mReady;
    expValid = (mq.size() != 0);
    head     = '{rw: 1'b0, dst: 5'd0, le: 4'd0, wd: 64'd0};
    if (expValid) head = mq[0];
    mReady = (mq.size() < 2) && !rst;
    if (mLive) begin
      checkOutput("mdl_out_valid", 64'(outValid), 64'(expValid));
      checkOutput("mdl_in_ready", 64'(inReady), 64'(mReady));
      checkOutput("mdl_out_regwrite", 64'(outRegwrite), 64'(head.rw));
      checkOutput("mdl_out_dst", 64'(outDst), 64'(head.dst));
      checkOutput("mdl_out_lane_en", 64'(outLaneEn), 64'(head.le));
      checkOutput("mdl_out_wdata", outWdata, head.wd);
      checkOutput("mdl_retire_cnt", 64'(retireCnt), 64'(mRetire));
    end
    if (rst) begin
      mq.delete();
      mRetire = 4'd0;
      mLive   = 1'b1;
    end else if (mLive) begin
      mPop  = expValid && outReady;
      mPush = inValid && mReady && !flush;
      if (mPop && head.rw) mRetire = mRetire + 4'd1;
      if (flush) begin
        mq.delete();
      end else begin
        if (mPop) void'(mq.pop_front());
        if (mPush) begin
          e.rw  = inRegwrite && (inDst != 5'd0);
          e.dst = inDst;
          e.le  = inLaneEn;
          e.wd  = inMemtoreg ? inDmemrd : inAlu;
          mq.push_back(e);
        end
      end
    end
  end

  // Drive one cycle of inputs, then return shortly after the capturing edge.
  task automatic applyStimulus(input logic v, input logic m2r, input logic rw,
                               input logic [4:0] dst, input logic [3:0] le,
                               input logic [63:0] dm, input logic [63:0] alu,
                               input logic fl, input logic ordy);
    inValid    = v;
    inMemtoreg = m2r;
    inRegwrite = rw;
    inDst      = dst;
    inLaneEn   = le;
    inDmemrd   = dm;
    inAlu      = alu;
    flush      = fl;
    outReady   = ordy;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 64'd0, 64'd0, 1'b0, ordy);
  endtask

  task automatic pushAlu(input logic [4:0] dst, input logic [63:0] alu, input logic ordy);
    applyStimulus(1'b1, 1'b0, 1'b1, dst, 4'b0001, 64'hFFFF, alu, 1'b0, ordy);
  endtask

  initial begin
    logic [63:0] dmVec;
    logic [63:0] aluVec;
    dmVec  = 64'h4444_3333_2222_1111;
    aluVec = 64'hDDDD_CCCC_BBBB_AAAA;

    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    checkOutput("rst_in_ready", 64'(inReady), 64'd0);
    checkOutput("rst_out_valid", 64'(outValid), 64'd0);
    checkOutput("rst_retire", 64'(retireCnt), 64'd0);
    rst = 1'b0;
    idle(1'b0);
    checkOutput("post_rst_in_ready", 64'(inReady), 64'd1);

    // Load-data writeback to x5.
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd5, 4'b0001, 64'hAA, 64'h55, 1'b0, 1'b1);
    checkOutput("ld_out_valid", 64'(outValid), 64'd1);
    checkOutput("ld_out_wdata", outWdata, 64'hAA);
    checkOutput("ld_out_dst", 64'(outDst), 64'd5);
    checkOutput("ld_retire_before", 64'(retireCnt), 64'd0);
    idle(1'b1);
    checkOutput("ld_retire_after", 64'(retireCnt), 64'd1);
    checkOutput("ld_empty", 64'(outValid), 64'd0);

    // Write to x0 is suppressed.
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd0, 4'b0001, 64'hAA, 64'h1234, 1'b0, 1'b0);
    checkOutput("x0_regwrite", 64'(outRegwrite), 64'd0);
    checkOutput("x0_wdata", outWdata, 64'h1234);
    idle(1'b1);
    checkOutput("x0_retire", 64'(retireCnt), 64'd1);

    // Fill both slots, hold off a third, drain in order.
    pushAlu(5'd1, 64'h11, 1'b0);
    pushAlu(5'd2, 64'h22, 1'b0);
    checkOutput("full_in_ready", 64'(inReady), 64'd0);
    checkOutput("full_head_dst", 64'(outDst), 64'd1);
    pushAlu(5'd3, 64'h33, 1'b0);
    checkOutput("held_head_dst", 64'(outDst), 64'd1);
    idle(1'b1);
    checkOutput("drain1_dst", 64'(outDst), 64'd2);
    checkOutput("drain1_in_ready", 64'(inReady), 64'd1);
    checkOutput("drain1_retire", 64'(retireCnt), 64'd2);
    idle(1'b1);
    checkOutput("drain2_valid", 64'(outValid), 64'd0);
    checkOutput("drain2_retire", 64'(retireCnt), 64'd3);

    // Flush a full buffer while a new entry is offered.
    pushAlu(5'd4, 64'h44, 1'b0);
    pushAlu(5'd6, 64'h66, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd7, 4'b0001, 64'd0, 64'h77, 1'b1, 1'b0);
    checkOutput("flush_valid", 64'(outValid), 64'd0);
    checkOutput("flush_retire", 64'(retireCnt), 64'd3);
    idle(1'b1);
    checkOutput("flush_dropped", 64'(outValid), 64'd0);

    // Flush together with a pop still retires the popped head.
    pushAlu(5'd8, 64'h88, 1'b0);
    pushAlu(5'd9, 64'h99, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd12, 4'b0001, 64'd0, 64'hCC, 1'b1, 1'b1);
    checkOutput("flushpop_retire", 64'(retireCnt), 64'd4);
    checkOutput("flushpop_valid", 64'(outValid), 64'd0);

    // Multi-lane entries with alternating data source.
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd10, 4'b0101, dmVec, aluVec, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd11, 4'b0101, dmVec, aluVec, 1'b0, 1'b0);
    checkOutput("lane_en_ld", 64'(outLaneEn), 64'b0101);
    for (int i = 0; i < NLANES; i++)
      checkOutput($sformatf("lane%0d_ld", i), 64'(outWdata[i*XLEN +: XLEN]), 64'(dmVec[i*XLEN +: XLEN]));
    idle(1'b1);
    checkOutput("lane_en_alu", 64'(outLaneEn), 64'b0101);
    checkOutput("lane_dst_alu", 64'(outDst), 64'd11);
    checkOutput("lane_retire", 64'(retireCnt), 64'd5);
    for (int i = 0; i < NLANES; i++)
      checkOutput($sformatf("lane%0d_alu", i), 64'(outWdata[i*XLEN +: XLEN]), 64'(aluVec[i*XLEN +: XLEN]));

    // Reset with two entries held and a push offered.
    pushAlu(5'd13, 64'hDD, 1'b0);
    checkOutput("prereset_full", 64'(inReady), 64'd0);
    rst = 1'b1;
    pushAlu(5'd14, 64'hEE, 1'b1);
    checkOutput("midrst_valid", 64'(outValid), 64'd0);
    checkOutput("midrst_dst", 64'(outDst), 64'd0);
    checkOutput("midrst_wdata", outWdata, 64'd0);
    checkOutput("midrst_lane_en", 64'(outLaneEn), 64'd0);
    checkOutput("midrst_retire", 64'(retireCnt), 64'd0);
    checkOutput("midrst_in_ready", 64'(inReady), 64'd0);
    rst = 1'b0;
    idle(1'b0);
    checkOutput("postrst_in_ready", 64'(inReady), 64'd1);
    checkOutput("postrst_valid", 64'(outValid), 64'd0);

    // Streaming push+pop; the 4-bit retire counter wraps after 16 writes.
    for (int i = 0; i < 16; i++)
      pushAlu(5'(i + 1), 64'(i), 1'b1);
    checkOutput("stream_retire15", 64'(retireCnt), 64'hF);
    checkOutput("stream_head_dst", 64'(outDst), 64'd16);
    idle(1'b1);
    checkOutput("stream_wrap", 64'(retireCnt), 64'd0);
    idle(1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
